core_s1_fetch: RTL and testbench

CORE_S1_FETCH -- requirements
Module: core_s1_fetch

---
 rtl/core_s1_fetch.sv | 163 ++++++++++++++++
 tb/tb_core_s1_fetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_s1_fetch.sv
// Stage-1 instruction fetch: issues one L1I request at a time, holds the
// returned word for stage 2, and handles redirects, misaligned targets,
// in-flight response discarding and a permanent halt.
module core_s1_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        l1i_req_valid,
    input  logic        l1i_req_ready,
    output logic [31:0] l1i_req_addr,
    input  logic        l1i_rsp_valid,
    input  logic [31:0] l1i_rsp_data,
    input  logic        l1i_rsp_fault,
    output logic        s2_valid,
    input  logic        s2_ready,
    output logic [31:0] s2_instruction,
    output logic [31:0] s2_pc,
    output logic        s2_fetch_fault,
    input  logic        s2_redirect,
    input  logic [31:0] s2_redirect_pc,
    input  logic        s2_halt
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        REQUEST  = 3'd1,
        WAIT_RSP = 3'd2,
        HOLD     = 3'd3,
        DISCARD  = 3'd4,
        HALTED   = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_fault;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_hold_we;
    logic [31:0] w_hold_instr;
    logic        w_hold_fault;
    logic        w_go;
    logic [31:0] w_go_pc;
    logic        w_in_hold;

    // Next-state logic; w_go/w_go_pc request "start fetching at this PC",
    // which becomes a fault entry instead of a request when misaligned.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_hold_we    = 1'b0;
        w_hold_instr = r_instr;
        w_hold_fault = r_fault;
        w_go         = 1'b0;
        w_go_pc      = r_pc;

        case (r_state)
            INIT: begin
                w_go    = 1'b1;
                w_go_pc = s2_redirect ? s2_redirect_pc : r_pc;
            end
            REQUEST: begin
                if (s2_redirect) begin
                    if (l1i_req_ready) begin
                        // The old request is accepted anyway; its response must be dropped.
                        w_state_nxt = DISCARD;
                        w_pc_nxt    = s2_redirect_pc;
                    end else begin
                        w_go    = 1'b1;
                        w_go_pc = s2_redirect_pc;
                    end
                end else if (l1i_req_ready) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (s2_redirect) begin
                    if (l1i_rsp_valid) begin
                        w_go    = 1'b1;
                        w_go_pc = s2_redirect_pc;
                    end else begin
                        w_state_nxt = DISCARD;
                        w_pc_nxt    = s2_redirect_pc;
                    end
                end else if (l1i_rsp_valid) begin
                    w_state_nxt  = HOLD;
                    w_hold_we    = 1'b1;
                    w_hold_instr = l1i_rsp_data;
                    w_hold_fault = l1i_rsp_fault;
                end
            end
            HOLD: begin
                if (s2_redirect) begin
                    w_go    = 1'b1;
                    w_go_pc = s2_redirect_pc;
                end else if (s2_ready) begin
                    w_go    = 1'b1;
                    w_go_pc = r_pc + 32'd4;
                end
            end
            DISCARD: begin
                if (l1i_rsp_valid) begin
                    w_go    = 1'b1;
                    w_go_pc = s2_redirect ? s2_redirect_pc : r_pc;
                end else if (s2_redirect) begin
                    w_pc_nxt = s2_redirect_pc;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = HALTED;
            end
        endcase

        if (w_go) begin
            w_pc_nxt = w_go_pc;
            if (w_go_pc[1:0] != 2'b00) begin
                w_state_nxt  = HOLD;
                w_hold_we    = 1'b1;
                w_hold_instr = 32'h0;
                w_hold_fault = 1'b1;
            end else begin
                w_state_nxt = REQUEST;
            end
        end

        if (s2_halt) begin
            w_state_nxt = HALTED;
        end
    end

    // Control state and PC, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Hold register; only visible while in HOLD, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_hold_we) begin
            r_instr <= w_hold_instr;
            r_fault <= w_hold_fault;
        end
    end

    assign w_in_hold      = (r_state == HOLD);
    assign l1i_req_valid  = (r_state == REQUEST);
    assign l1i_req_addr   = l1i_req_valid ? r_pc : 32'h0;
    assign s2_valid       = w_in_hold;
    assign s2_instruction = w_in_hold ? r_instr : 32'h0;
    assign s2_pc          = w_in_hold ? r_pc : 32'h0;
    assign s2_fetch_fault = w_in_hold & r_fault;

endmodule

// File: tb/tb_core_s1_fetch.sv
// Testbench for core_s1_fetch: table-driven fetches with a scoreboard of
// expected stage-2 entries, plus hand sequences for redirect/halt/reset.
module tb_core_s1_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l1i_req_valid, l1i_req_ready;
    logic [31:0] l1i_req_addr;
    logic        l1i_rsp_valid, l1i_rsp_fault;
    logic [31:0] l1i_rsp_data;
    logic        s2_valid, s2_ready, s2_fetch_fault, s2_redirect, s2_halt;
    logic [31:0] s2_instruction, s2_pc, s2_redirect_pc;

    logic        rst_n2;
    logic        req_valid2, req_ready2;
    logic [31:0] req_addr2;
    logic        rsp_valid2, rsp_fault2;
    logic [31:0] rsp_data2;
    logic        s2_valid2, s2_ready2, s2_fault2, s2_redirect2, s2_halt2;
    logic [31:0] s2_instr2, s2_pc2, s2_redirect_pc2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          rdy_dly;
        int          rsp_dly;
        int          hold;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } sb_t;

    vec_t vecs[4];
    sb_t  sbq[$];

    always #5 clk = ~clk;

    core_s1_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .l1i_req_valid(l1i_req_valid), .l1i_req_ready(l1i_req_ready), .l1i_req_addr(l1i_req_addr),
        .l1i_rsp_valid(l1i_rsp_valid), .l1i_rsp_data(l1i_rsp_data), .l1i_rsp_fault(l1i_rsp_fault),
        .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_instruction(s2_instruction), .s2_pc(s2_pc),
        .s2_fetch_fault(s2_fetch_fault), .s2_redirect(s2_redirect), .s2_redirect_pc(s2_redirect_pc),
        .s2_halt(s2_halt)
    );

    core_s1_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n2),
        .l1i_req_valid(req_valid2), .l1i_req_ready(req_ready2), .l1i_req_addr(req_addr2),
        .l1i_rsp_valid(rsp_valid2), .l1i_rsp_data(rsp_data2), .l1i_rsp_fault(rsp_fault2),
        .s2_valid(s2_valid2), .s2_ready(s2_ready2), .s2_instruction(s2_instr2), .s2_pc(s2_pc2),
        .s2_fetch_fault(s2_fault2), .s2_redirect(s2_redirect2), .s2_redirect_pc(s2_redirect_pc2),
        .s2_halt(s2_halt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int k;
        k = 0;
        while (l1i_req_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("req_seen", l1i_req_valid, 1);
        chk("req_addr", l1i_req_addr, exp_addr);
    endtask

    task automatic issue(input int rdy_dly, input logic [31:0] exp_addr);
        for (int i = 0; i < rdy_dly; i++) begin
            l1i_req_ready = 1'b0;
            tick();
            chk("req_valid_stall", l1i_req_valid, 1);
            chk("req_addr_stall", l1i_req_addr, exp_addr);
        end
        l1i_req_ready = 1'b1;
        tick();
        l1i_req_ready = 1'b0;
        chk("req_valid_after_accept", l1i_req_valid, 0);
    endtask

    task automatic respond(input int dly, input logic [31:0] data, input logic fault,
                           input logic [31:0] pc);
        sb_t e;
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("s2_valid_waiting", s2_valid, 0);
            chk("req_valid_waiting", l1i_req_valid, 0);
        end
        l1i_rsp_valid = 1'b1;
        l1i_rsp_data  = data;
        l1i_rsp_fault = fault;
        e.pc = pc; e.instr = data; e.fault = fault;
        sbq.push_back(e);
        tick();
        l1i_rsp_valid = 1'b0;
        l1i_rsp_data  = 32'h0;
        l1i_rsp_fault = 1'b0;
    endtask

    task automatic consume(input int hold);
        sb_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            chk("s2_valid_held", s2_valid, 1);
            chk("s2_pc_held", s2_pc, sbq[0].pc);
            chk("s2_instr_held", s2_instruction, sbq[0].instr);
            tick();
        end
        e = sbq.pop_front();
        chk("s2_valid", s2_valid, 1);
        chk("s2_pc", s2_pc, e.pc);
        chk("s2_instr", s2_instruction, e.instr);
        chk("s2_fault", s2_fetch_fault, e.fault);
        s2_ready = 1'b1;
        tick();
        s2_ready = 1'b0;
    endtask

    task automatic run_fetch(input vec_t v);
        wait_req(v.exp_pc);
        issue(v.rdy_dly, v.exp_pc);
        respond(v.rsp_dly, v.data, v.fault, v.exp_pc);
        consume(v.hold);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, l1i_req_valid, 0);
        chk({tag, "_req_addr"}, l1i_req_addr, 0);
        chk({tag, "_s2_valid"}, s2_valid, 0);
        chk({tag, "_s2_instr"}, s2_instruction, 0);
        chk({tag, "_s2_pc"}, s2_pc, 0);
        chk({tag, "_s2_fault"}, s2_fetch_fault, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        vecs[0] = '{32'h0000_0013, 1'b0, 0, 0, 0, 32'h0000_0000};
        vecs[1] = '{32'h1234_5678, 1'b0, 5, 1, 2, 32'h0000_0004};
        vecs[2] = '{32'hCAFE_F00D, 1'b1, 0, 2, 1, 32'h0000_0008};
        vecs[3] = '{32'h0000_0000, 1'b0, 1, 0, 3, 32'h0000_000C};

        rst_n = 1'b0; l1i_req_ready = 1'b0; l1i_rsp_valid = 1'b0; l1i_rsp_data = 32'h0;
        l1i_rsp_fault = 1'b0; s2_ready = 1'b0; s2_redirect = 1'b0; s2_redirect_pc = 32'h0;
        s2_halt = 1'b0;
        rst_n2 = 1'b0; req_ready2 = 1'b0; rsp_valid2 = 1'b0; rsp_data2 = 32'h0;
        rsp_fault2 = 1'b0; s2_ready2 = 1'b0; s2_redirect2 = 1'b0; s2_redirect_pc2 = 32'h0;
        s2_halt2 = 1'b0;

        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_fetch(vecs[i]);
        end

        // Redirect during WAIT_RSP; response arrives two cycles later and is dropped.
        wait_req(32'h10);
        issue(0, 32'h10);
        s2_redirect = 1'b1; s2_redirect_pc = 32'h100;
        tick();
        s2_redirect = 1'b0;
        chk("discard_req_valid", l1i_req_valid, 0);
        tick();
        l1i_rsp_valid = 1'b1; l1i_rsp_data = 32'hDEAD_BEEF;
        tick();
        l1i_rsp_valid = 1'b0; l1i_rsp_data = 32'h0;
        chk("drop_s2_valid", s2_valid, 0);
        v = '{32'hA5A5_0001, 1'b0, 0, 0, 0, 32'h0000_0100};
        run_fetch(v);

        // Misaligned redirect in REQUEST: no request, fault entry at 0x102.
        wait_req(32'h104);
        s2_redirect = 1'b1; s2_redirect_pc = 32'h102;
        tick();
        s2_redirect = 1'b0;
        chk("mis_req_valid", l1i_req_valid, 0);
        chk("mis_s2_valid", s2_valid, 1);
        chk("mis_s2_fault", s2_fetch_fault, 1);
        chk("mis_s2_pc", s2_pc, 32'h102);
        chk("mis_s2_instr", s2_instruction, 0);

        // Redirect in HOLD beats s2_ready; held entry dropped.
        s2_redirect = 1'b1; s2_redirect_pc = 32'h200; s2_ready = 1'b1;
        tick();
        s2_redirect = 1'b0; s2_ready = 1'b0;
        chk("hold_redir_s2_valid", s2_valid, 0);
        chk("hold_redir_req_addr", l1i_req_addr, 32'h200);

        // Redirect in REQUEST while not ready: new address next cycle.
        s2_redirect = 1'b1; s2_redirect_pc = 32'h300;
        tick();
        s2_redirect = 1'b0;
        chk("req_redir_valid", l1i_req_valid, 1);
        chk("req_redir_addr", l1i_req_addr, 32'h300);

        // Redirect in REQUEST with ready: old request completes, then DISCARD.
        s2_redirect = 1'b1; s2_redirect_pc = 32'h400; l1i_req_ready = 1'b1;
        tick();
        s2_redirect = 1'b0; l1i_req_ready = 1'b0;
        chk("req_rdy_redir_valid", l1i_req_valid, 0);
        s2_redirect = 1'b1; s2_redirect_pc = 32'h402;
        tick();
        s2_redirect = 1'b0;
        chk("disc_redir_req_valid", l1i_req_valid, 0);
        chk("disc_redir_s2_valid", s2_valid, 0);
        l1i_rsp_valid = 1'b1; l1i_rsp_data = 32'h0000_0BAD;
        tick();
        l1i_rsp_valid = 1'b0; l1i_rsp_data = 32'h0;
        chk("disc_mis_s2_valid", s2_valid, 1);
        chk("disc_mis_s2_fault", s2_fetch_fault, 1);
        chk("disc_mis_s2_pc", s2_pc, 32'h402);
        chk("disc_mis_s2_instr", s2_instruction, 0);

        // Halt and redirect together in HOLD: halt wins, stays halted.
        s2_halt = 1'b1; s2_redirect = 1'b1; s2_redirect_pc = 32'h500;
        tick();
        s2_halt = 1'b0; s2_redirect = 1'b0;
        chk_all_zero("halted");
        l1i_rsp_valid = 1'b1; l1i_rsp_data = 32'h1111_1111;
        tick();
        l1i_rsp_valid = 1'b0; l1i_rsp_data = 32'h0;
        s2_redirect = 1'b1; s2_redirect_pc = 32'h600;
        tick();
        s2_redirect = 1'b0;
        chk_all_zero("halted_late");

        // Reset pulse restarts at RESET_PC.
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_pulse");
        tick();
        rst_n = 1'b1;
        wait_req(32'h0);

        // Reset while a response is outstanding abandons it.
        issue(0, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_s2_valid", s2_valid, 0);
        wait_req(32'h0);

        // RESET_PC at the top of the address space wraps to 0; fault is carried.
        rst_n2 = 1'b1;
        tick();
        chk("wrap_req_valid", req_valid2, 1);
        chk("wrap_req_addr", req_addr2, 32'hFFFF_FFFC);
        req_ready2 = 1'b1;
        tick();
        req_ready2 = 1'b0;
        chk("wrap_wait_req_valid", req_valid2, 0);
        rsp_valid2 = 1'b1; rsp_data2 = 32'h0000_0013; rsp_fault2 = 1'b1;
        tick();
        rsp_valid2 = 1'b0; rsp_data2 = 32'h0; rsp_fault2 = 1'b0;
        chk("wrap_s2_valid", s2_valid2, 1);
        chk("wrap_s2_fault", s2_fault2, 1);
        chk("wrap_s2_pc", s2_pc2, 32'hFFFF_FFFC);
        chk("wrap_s2_instr", s2_instr2, 32'h0000_0013);
        s2_ready2 = 1'b1;
        tick();
        s2_ready2 = 1'b0;
        chk("wrap_next_valid", req_valid2, 1);
        chk("wrap_next_addr", req_addr2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
